// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Handshake and data bundle for the sequential divider.
//   start       : request, honoured only while ready is high
//   dividend    : N-bit unsigned operand, captured on the accepting edge
//   divisor     : M-bit unsigned operand, captured on the accepting edge
//   ready       : divider idle and able to accept start
//   busy        : division in progress
//   done        : one-cycle pulse, results valid from this cycle
//   quotient    : N-bit result, held until the next operation completes
//   remainder   : M-bit result, held until the next operation completes
//   div_by_zero : result came from a zero divisor
// master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int N = 8,
   parameter int M = 4
);
   logic         start;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         ready;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [M-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider: N-bit unsigned dividend / M-bit unsigned
// divisor -> N-bit quotient and M-bit remainder, one quotient bit per clock.
// A zero divisor bypasses the iteration and completes in a single cycle with
// quotient = all ones, remainder = 0 and div_by_zero set.
// Ports:
//   i_clk   : clock, rising edge active
//   i_rst_n : asynchronous active-low reset
//   bus     : seq_divider_if.slave (start/ready/busy/done handshake + data)
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   seq_divider_if.slave  bus
);

   localparam int CW = $clog2(N);
   localparam int RW = M + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [N-1:0]    r_d;
   logic [M-1:0]    r_v;
   logic [RW-1:0]   r_r;
   logic [N-1:0]    r_q;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_quot;
   logic [M-1:0]    r_rem;
   logic            r_dbz;

   logic [RW-1:0]   w_t;
   logic            w_ge;
   logic [RW-1:0]   w_r_next;
   logic [N-1:0]    w_q_next;
   logic            w_div_zero;
   logic            w_ready;
   logic            w_busy;
   logic            w_done;

   assign w_div_zero = (bus.divisor == {M{1'b0}});

   // One restoring step. R[M] is always 0 between steps, so truncating the
   // shifted value to M+1 bits equals {R[M-1:0], D[N-1]}.
   always_comb begin
      w_t      = RW'({r_r, r_d[N-1]});
      w_ge     = (w_t >= {1'b0, r_v});
      if (w_ge) begin
         w_r_next = w_t - {1'b0, r_v};
      end else begin
         w_r_next = w_t;
      end
      w_q_next = N'({r_q, w_ge});
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (w_div_zero) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_CALC;
               end
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_CALC: begin
            if (r_cnt == {CW{1'b0}}) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_CALC;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Handshake outputs, decoded from the state register.
   always_comb begin
      w_ready = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE:  w_ready = 1'b1;
         S_CALC:  w_busy  = 1'b1;
         S_DONE:  w_done  = 1'b1;
         default: w_ready = 1'b0;
      endcase
   end

   // Datapath: operand capture, iteration and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_d    <= {N{1'b0}};
         r_v    <= {M{1'b0}};
         r_r    <= {RW{1'b0}};
         r_q    <= {N{1'b0}};
         r_cnt  <= {CW{1'b0}};
         r_quot <= {N{1'b0}};
         r_rem  <= {M{1'b0}};
         r_dbz  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_div_zero) begin
                     r_quot <= {N{1'b1}};
                     r_rem  <= {M{1'b0}};
                     r_dbz  <= 1'b1;
                  end else begin
                     r_d   <= bus.dividend;
                     r_v   <= bus.divisor;
                     r_r   <= {RW{1'b0}};
                     r_q   <= {N{1'b0}};
                     r_cnt <= CW'(N - 1);
                  end
               end else begin
                  r_d <= r_d;
               end
            end
            S_CALC: begin
               r_d <= N'({r_d, 1'b0});
               r_r <= w_r_next;
               r_q <= w_q_next;
               if (r_cnt == {CW{1'b0}}) begin
                  r_quot <= w_q_next;
                  r_rem  <= w_r_next[M-1:0];
                  r_dbz  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_d <= r_d;
            end
         endcase
      end
   end

   assign bus.ready       = w_ready;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule
